csr_trap_ctrl: RTL

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// CSR access, trap entry and MRET sequencer in front of a single-port CSR register file.
// One request is serviced at a time; trap outranks MRET, which outranks ordinary CSR instructions.
module csr_trap_ctrl #(
    parameter logic [63:0] MTVEC_BASE = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_req_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [63:0] csr_wdata_i,
    output logic        csr_gnt_o,
    output logic        csr_done_o,
    output logic [63:0] csr_rdata_o,
    input  logic        trap_req_i,
    input  logic [63:0] trap_cause_i,
    input  logic [63:0] trap_pc_i,
    input  logic        mret_req_i,
    output logic        trap_ack_o,
    output logic        mret_ack_o,
    output logic        redirect_o,
    output logic [63:0] redirect_pc_o,
    output logic [11:0] reg_addr_o,
    output logic [63:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic [1:0]  reg_type_o,
    input  logic [63:0] reg_rdata_i,
    output logic        busy_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [1:0] TYPE_SWAP = 2'b00;
    localparam logic [1:0] TYPE_EPC  = 2'b11;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        CSR_RSP,
        T_EPC,
        T_CAUSE,
        T_SRD,
        T_SWR,
        T_DONE,
        M_EPC,
        M_SRD,
        M_SWR,
        M_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_rdata;
    logic [63:0] r_epc;

    logic        w_idle;
    logic        w_take_trap;
    logic        w_take_mret;
    logic        w_grant;
    logic        w_csr_we;
    logic [63:0] w_trap_mstatus;
    logic [63:0] w_mret_mstatus;

    // IDLE decisions are masked while reset is held so no grant leaks out during reset.
    assign w_idle      = (r_state == IDLE) && rst_i;
    assign w_take_trap = w_idle && trap_req_i;
    assign w_take_mret = w_idle && !trap_req_i && mret_req_i;
    assign w_grant     = w_idle && csr_req_i && !trap_req_i && !mret_req_i;

    // Set/clear with a zero mask and plain reads leave the CSR untouched.
    assign w_csr_we = !((csr_op_i == OP_READ) ||
                        ((csr_op_i != TYPE_SWAP) && (csr_wdata_i == 64'h0)));

    assign csr_gnt_o = w_grant;
    assign busy_o    = (r_state != IDLE);

    always_comb begin
        w_trap_mstatus        = reg_rdata_i;
        w_trap_mstatus[7]     = reg_rdata_i[3];
        w_trap_mstatus[3]     = 1'b0;
        w_trap_mstatus[12:11] = 2'b11;

        w_mret_mstatus        = reg_rdata_i;
        w_mret_mstatus[3]     = reg_rdata_i[7];
        w_mret_mstatus[7]     = 1'b1;
        w_mret_mstatus[12:11] = 2'b00;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_trap) begin
                    w_next = T_EPC;
                end else if (w_take_mret) begin
                    w_next = M_EPC;
                end else if (w_grant) begin
                    w_next = CSR_RSP;
                end
            end
            CSR_RSP: w_next = IDLE;
            T_EPC:   w_next = T_CAUSE;
            T_CAUSE: w_next = T_SRD;
            T_SRD:   w_next = T_SWR;
            T_SWR:   w_next = T_DONE;
            T_DONE:  w_next = IDLE;
            M_EPC:   w_next = M_SRD;
            M_SRD:   w_next = M_SWR;
            M_SWR:   w_next = M_DONE;
            M_DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Register-file port and completion pulses; read data always arrives one cycle after its address.
    always_comb begin
        csr_done_o    = 1'b0;
        csr_rdata_o   = r_rdata;
        trap_ack_o    = 1'b0;
        mret_ack_o    = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = 64'h0;
        reg_addr_o    = 12'h0;
        reg_wdata_o   = 64'h0;
        reg_we_o      = 1'b0;
        reg_type_o    = TYPE_SWAP;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    reg_addr_o  = csr_addr_i;
                    reg_wdata_o = csr_wdata_i;
                    reg_type_o  = csr_op_i;
                    reg_we_o    = w_csr_we;
                end
            end
            CSR_RSP: begin
                csr_done_o  = 1'b1;
                csr_rdata_o = reg_rdata_i;
            end
            T_EPC: begin
                reg_addr_o  = ADDR_MEPC;
                reg_wdata_o = trap_pc_i & ~64'h3;
                reg_type_o  = TYPE_EPC;
                reg_we_o    = 1'b1;
            end
            T_CAUSE: begin
                reg_addr_o  = ADDR_MCAUSE;
                reg_wdata_o = trap_cause_i;
                reg_we_o    = 1'b1;
            end
            T_SRD: begin
                reg_addr_o = ADDR_MSTATUS;
            end
            T_SWR: begin
                reg_addr_o  = ADDR_MSTATUS;
                reg_wdata_o = w_trap_mstatus;
                reg_we_o    = 1'b1;
            end
            T_DONE: begin
                trap_ack_o    = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = MTVEC_BASE;
            end
            M_EPC: begin
                reg_addr_o = ADDR_MEPC;
            end
            M_SRD: begin
                reg_addr_o = ADDR_MSTATUS;
            end
            M_SWR: begin
                reg_addr_o  = ADDR_MSTATUS;
                reg_wdata_o = w_mret_mstatus;
                reg_we_o    = 1'b1;
            end
            M_DONE: begin
                mret_ack_o    = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = r_epc & ~64'h3;
            end
            default: begin
                reg_we_o = 1'b0;
            end
        endcase
    end

    // The returned CSR value is held until the next completion; mepc is captured mid-MRET.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_rdata <= 64'h0;
            r_epc   <= 64'h0;
        end else begin
            r_state <= w_next;
            if (r_state == CSR_RSP) begin
                r_rdata <= reg_rdata_i;
            end
            if (r_state == M_SRD) begin
                r_epc <= reg_rdata_i;
            end
        end
    end

endmodule
